// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC register / instruction fetch block.
package pc_fetch_unit_pkg;

  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_timeout_ctr.sv
// Counts cycles spent waiting for an instruction response.
// expire is high while the count sits at TIMEOUT_CYCLES-1.
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register plus single-outstanding instruction fetch FSM.
// The held instruction stays valid until the core retires it.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int              TIMEOUT_CYCLES = 64,
  parameter int              CNT_W          = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ILEN-1:0] pc_next_i,
  input  logic            retire_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [ILEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  output logic [ILEN-1:0] pc_o,
  output logic [ILEN-1:0] pc_plus4_o,
  output logic [ILEN-1:0] instr_o,
  output logic            instr_valid_o,
  output logic            misalign_err_o,
  output logic            timeout_err_o
);

  fetch_state_e state, next_state;

  logic [ILEN-1:0] pc_q;
  logic req_valid, accept, load_instr, retire_ok, set_misalign, set_timeout;
  logic ctr_en, ctr_expire;

  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (ctr_en),
    .expire(ctr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state   = state;
    req_valid    = 1'b0;
    accept       = 1'b0;
    load_instr   = 1'b0;
    retire_ok    = 1'b0;
    set_misalign = 1'b0;
    set_timeout  = 1'b0;
    ctr_en       = 1'b0;
    unique case (state)
      FETCH: begin
        req_valid = 1'b1;
        if (imem_req_ready_i) begin
          accept     = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        ctr_en = 1'b1;
        // A response on the expiring cycle still wins over the timeout.
        if (imem_rsp_valid_i) begin
          load_instr = 1'b1;
          next_state = HOLD;
        end else if (ctr_expire) begin
          set_timeout = 1'b1;
          next_state  = ERR;
        end
      end
      HOLD: begin
        if (retire_i) begin
          retire_ok = 1'b1;
          if (pc_next_i[1:0] != 2'b00) begin
            set_misalign = 1'b1;
            next_state   = ERR;
          end else begin
            next_state = FETCH;
          end
        end
      end
      ERR: ;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      instr_o        <= '0;
      instr_valid_o  <= 1'b0;
      misalign_err_o <= 1'b0;
      timeout_err_o  <= 1'b0;
    end else begin
      if (load_instr) begin
        instr_o       <= imem_rsp_data_i;
        instr_valid_o <= 1'b1;
      end
      // A misaligned target is still loaded so it is visible for debug.
      if (retire_ok) begin
        pc_q          <= pc_next_i;
        instr_valid_o <= 1'b0;
      end
      if (set_misalign) misalign_err_o <= 1'b1;
      if (set_timeout)  timeout_err_o  <= 1'b1;
    end
  end

  // Request is suppressed while reset is asserted, whatever the old state.
  assign imem_req_valid_o = req_valid && !rst;
  assign pc_o             = pc_q;
  assign imem_addr_o      = pc_q;
  assign pc_plus4_o       = pc_q + 32'd4;

endmodule
